// File: rtl/labka_13.sv
// labka_13: registered 4-input Boolean function generator.
// The function is fixed by TRUTH_TABLE (bit i = f(x) for x == i) and is
// evaluated through a Shannon expansion on x[0]: an 8:1 mux selected by
// x[3:1] whose data legs are each one of {0, 1, x[0], ~x[0]}. The leg kind
// is chosen at elaboration time from the table pair for that select value.
// The result is registered; out follows x with exactly one cycle of latency.
module labka_13 #(
   parameter logic [15:0] TRUTH_TABLE = 16'hD29A,
   parameter logic        RESET_VALUE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] x,
   output logic       out
);

   // Mux data legs, one per value of x[3:1]
   logic [7:0] leg;
   logic       out_d;
   logic       out_q;

   // Build each leg from the pair (f(2s), f(2s+1)), i.e. f with x[0]=0 and x[0]=1
   for (genvar s = 0; s < 8; s++) begin : g_leg
      localparam logic F_LO = TRUTH_TABLE[2*s];
      localparam logic F_HI = TRUTH_TABLE[2*s+1];
      if (!F_LO && !F_HI) begin : g_zero
         assign leg[s] = 1'b0;
      end else if (F_LO && F_HI) begin : g_one
         assign leg[s] = 1'b1;
      end else if (!F_LO && F_HI) begin : g_pos
         assign leg[s] = x[0];
      end else begin : g_neg
         assign leg[s] = ~x[0];
      end
   end

   // 8:1 select on the upper three input bits; unknowns on x pass straight through
   always_comb begin
      out_d = leg[x[3:1]];
   end

   // Output register with synchronous active-low reset; x is ignored during reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= RESET_VALUE;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_labka_13.sv
// Bench for labka_13: default table plus parity, all-zero and all-one
// overrides driven in parallel from the same x / rst_n.
module tb_labka_13;

   logic       clk;
   logic       rst_n;
   logic [3:0] x;
   logic       out_def;
   logic       out_par;
   logic       out_zero;
   logic       out_ones;

   int n_checks;
   int n_fail;

   logic exp_q[$];

   // Default function, hand-written: out vs x = 0..15
   logic def_exp[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   typedef struct packed {
      logic       rst_n;
      logic [3:0] x;
      logic       exp_o;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs[NVEC];

   labka_13 dut_def (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .out   (out_def)
   );

   labka_13 #(.TRUTH_TABLE(16'h6996)) dut_par (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .out   (out_par)
   );

   labka_13 #(.TRUTH_TABLE(16'h0000)) dut_zero (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .out   (out_zero)
   );

   labka_13 #(.TRUTH_TABLE(16'hFFFF)) dut_ones (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .out   (out_ones)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst_n = 1'b0;
      x     = 4'hF;
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Driver: apply inputs away from the edge, clock once, then compare all four cells
   task automatic step(input logic r, input logic [3:0] xv, input logic exp_d);
      logic e;
      @(negedge clk);
      rst_n = r;
      x     = xv;
      exp_q.push_back(exp_d);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("default r=%b x=%h", r, xv), out_def, e);
      check($sformatf("parity r=%b x=%h", r, xv), out_par, r ? ^xv : 1'b0);
      check($sformatf("zero r=%b x=%h", r, xv), out_zero, 1'b0);
      check($sformatf("ones r=%b x=%h", r, xv), out_ones, r);
   endtask

   initial begin
      logic [3:0] xv;
      n_checks = 0;
      n_fail   = 0;

      // Reset: 3 edges with x=F held
      vecs[0]  = '{rst_n: 1'b0, x: 4'hF, exp_o: 1'b0};
      vecs[1]  = '{rst_n: 1'b0, x: 4'hF, exp_o: 1'b0};
      vecs[2]  = '{rst_n: 1'b0, x: 4'hF, exp_o: 1'b0};
      // Up-count sweep
      vecs[3]  = '{rst_n: 1'b1, x: 4'h0, exp_o: 1'b0};
      vecs[4]  = '{rst_n: 1'b1, x: 4'h1, exp_o: 1'b1};
      vecs[5]  = '{rst_n: 1'b1, x: 4'h2, exp_o: 1'b0};
      vecs[6]  = '{rst_n: 1'b1, x: 4'h3, exp_o: 1'b1};
      vecs[7]  = '{rst_n: 1'b1, x: 4'h4, exp_o: 1'b1};
      vecs[8]  = '{rst_n: 1'b1, x: 4'h5, exp_o: 1'b0};
      vecs[9]  = '{rst_n: 1'b1, x: 4'h6, exp_o: 1'b0};
      vecs[10] = '{rst_n: 1'b1, x: 4'h7, exp_o: 1'b1};
      vecs[11] = '{rst_n: 1'b1, x: 4'h8, exp_o: 1'b0};
      vecs[12] = '{rst_n: 1'b1, x: 4'h9, exp_o: 1'b1};
      vecs[13] = '{rst_n: 1'b1, x: 4'hA, exp_o: 1'b0};
      vecs[14] = '{rst_n: 1'b1, x: 4'hB, exp_o: 1'b0};
      vecs[15] = '{rst_n: 1'b1, x: 4'hC, exp_o: 1'b1};
      vecs[16] = '{rst_n: 1'b1, x: 4'hD, exp_o: 1'b0};
      vecs[17] = '{rst_n: 1'b1, x: 4'hE, exp_o: 1'b1};
      vecs[18] = '{rst_n: 1'b1, x: 4'hF, exp_o: 1'b1};
      // Wrap F -> 0
      vecs[19] = '{rst_n: 1'b1, x: 4'h0, exp_o: 1'b0};
      // Reset mid-operation with x=7 held
      vecs[20] = '{rst_n: 1'b1, x: 4'h7, exp_o: 1'b1};
      vecs[21] = '{rst_n: 1'b0, x: 4'h7, exp_o: 1'b0};
      vecs[22] = '{rst_n: 1'b1, x: 4'h7, exp_o: 1'b1};

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst_n, vecs[i].x, vecs[i].exp_o);
      end

      // Slow sweep: each code held 5 cycles over 0..15, then 0..3 again
      for (int k = 0; k < 20; k++) begin
         xv = 4'(k % 16);
         for (int h = 0; h < 5; h++) begin
            step(1'b1, xv, def_exp[xv]);
         end
      end

      // Reset in the middle of a fast sweep, then first edge after release
      step(1'b1, 4'hE, 1'b1);
      step(1'b0, 4'hF, 1'b0);
      step(1'b1, 4'h4, 1'b1);
      step(1'b1, 4'h5, 1'b0);

      // Random x for 100 cycles
      for (int i = 0; i < 100; i++) begin
         xv = 4'($urandom_range(0, 15));
         step(1'b1, xv, def_exp[xv]);
      end

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard drain: got %0d leftover expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
